// File: rtl/target_box_tracker.sv
// ---------------------------------------------------------------------------
// target_box_tracker
//
// Per-frame bounding-box extractor. Each active pixel of the incoming video
// pack is classified against an RGB colour window (strong red, weak green and
// blue). The min/max x/y of matching pixels are accumulated across a frame.
// On every frame boundary (rising vsync) one box is published. The box then
// stays stable until the next publish.
//
// Ports:
//   clk        pixel clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   en         tracking enable, sampled only when a box is published
//   i_pack     video pack: [48] pclk (unused), [47] vsync, [46] hsync,
//              [45] de, [44:21] {r,g,b}, [20:10] x, [9:0] y
//   start_x/y  published top-left corner
//   end_x/y    published bottom-right corner (inclusive)
//   color      BOX_COLOR while box_valid, else 0
//   box_valid  published box is meaningful
//   pix_count  matching-pixel count of the last completed frame
//   frame_tick one-cycle pulse per publish
// ---------------------------------------------------------------------------
module target_box_tracker #(
  parameter int          H_ACT       = 1280,
  parameter int          V_ACT       = 720,
  parameter logic [7:0]  R_MIN       = 8'd160,
  parameter logic [7:0]  G_MAX       = 8'd80,
  parameter logic [7:0]  B_MAX       = 8'd80,
  parameter int          MIN_PIXELS  = 64,
  parameter int          HOLD_FRAMES = 3,
  parameter logic [23:0] BOX_COLOR   = 24'h00FF00,
  parameter int          CNT_W       = 20,
  localparam int         X_W         = $clog2(H_ACT),
  localparam int         Y_W         = $clog2(V_ACT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [48:0]      i_pack,
  output logic [X_W-1:0]   start_x,
  output logic [Y_W-1:0]   start_y,
  output logic [X_W-1:0]   end_x,
  output logic [Y_W-1:0]   end_y,
  output logic [23:0]      color,
  output logic             box_valid,
  output logic [CNT_W-1:0] pix_count,
  output logic             frame_tick
);

  // Wide enough to hold 0..HOLD_FRAMES. At least one bit is needed even when
  // HOLD_FRAMES is 0.
  localparam int MISS_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0]  MIN_CNT  = CNT_W'(MIN_PIXELS);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    ACCUM,
    PUBLISH
  } state_t;

  // -------------------------------------------------------------------------
  // Two-stage input pipeline
  // -------------------------------------------------------------------------
  logic [48:0]    p0;
  logic           p1_match;
  logic [X_W-1:0] p1_x;
  logic [Y_W-1:0] p1_y;
  logic           p1_vsync;
  logic           vsync_q;

  logic [7:0] p0_r, p0_g, p0_b;
  logic       match;

  assign p0_r  = p0[44:37];
  assign p0_g  = p0[36:29];
  assign p0_b  = p0[28:21];
  assign match = p0[45] && (p0_r >= R_MIN) && (p0_g <= G_MAX) && (p0_b <= B_MAX);

  // NOTE: sequential state is always written with non-blocking assignments,
  // so every register in a block samples pre-edge values, whatever the
  // statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0       <= '0;
      p1_match <= 1'b0;
      p1_x     <= '0;
      p1_y     <= '0;
      p1_vsync <= 1'b0;
      vsync_q  <= 1'b0;
    end else begin
      p0       <= i_pack;
      p1_match <= match;
      p1_x     <= p0[20:10];
      p1_y     <= p0[9:0];
      p1_vsync <= p0[47];
      vsync_q  <= p1_vsync;
    end
  end

  // A frame ends on the rising edge of the pipelined vsync.
  logic frame_end;
  assign frame_end = p1_vsync && !vsync_q;

  // -------------------------------------------------------------------------
  // Accumulators, FSM and registered outputs
  // -------------------------------------------------------------------------
  state_t            state;
  logic [X_W-1:0]    min_x, max_x;
  logic [Y_W-1:0]    min_y, max_y;
  logic [CNT_W-1:0]  cnt;
  logic [MISS_W-1:0] miss_cnt;

  // Next miss count for a failing frame. It saturates at HOLD_FRAMES.
  // Reaching HOLD_FRAMES drops the box.
  logic [MISS_W-1:0] miss_inc;
  logic              pass;
  logic              drop;

  assign miss_inc = (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + 1'b1;
  assign pass     = en && (cnt >= MIN_CNT);
  assign drop     = !en || (miss_inc == MISS_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_FRAME;
      min_x      <= '1;
      min_y      <= '1;
      max_x      <= '0;
      max_y      <= '0;
      cnt        <= '0;
      miss_cnt   <= '0;
      start_x    <= '0;
      start_y    <= '0;
      end_x      <= '0;
      end_y      <= '0;
      color      <= '0;
      box_valid  <= 1'b0;
      pix_count  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        // Throw away the partial frame that was in flight at reset.
        WAIT_FRAME: begin
          if (frame_end) begin
            min_x <= '1;
            min_y <= '1;
            max_x <= '0;
            max_y <= '0;
            cnt   <= '0;
            state <= ACCUM;
          end
        end

        // The frame edge takes priority. A pixel that matches on the edge
        // cycle is dropped, so it does not count toward either frame.
        ACCUM: begin
          if (frame_end) begin
            state <= PUBLISH;
          end else if (p1_match) begin
            if (p1_x < min_x) min_x <= p1_x;
            if (p1_x > max_x) max_x <= p1_x;
            if (p1_y < min_y) min_y <= p1_y;
            if (p1_y > max_y) max_y <= p1_y;
            if (cnt != '1) cnt <= cnt + 1'b1;
          end
        end

        PUBLISH: begin
          frame_tick <= 1'b1;
          pix_count  <= cnt;
          if (pass) begin
            start_x   <= min_x;
            start_y   <= min_y;
            end_x     <= max_x;
            end_y     <= max_y;
            color     <= BOX_COLOR;
            box_valid <= 1'b1;
            miss_cnt  <= '0;
          end else begin
            miss_cnt <= miss_inc;
            if (drop) begin
              start_x   <= '0;
              start_y   <= '0;
              end_x     <= '0;
              end_y     <= '0;
              color     <= '0;
              box_valid <= 1'b0;
            end
          end
          min_x <= '1;
          min_y <= '1;
          max_x <= '0;
          max_y <= '0;
          cnt   <= '0;
          state <= ACCUM;
        end

        default: state <= WAIT_FRAME;
      endcase
    end
  end

endmodule

// File: tb/tb_target_box_tracker.sv
// ---------------------------------------------------------------------------
// tb_target_box_tracker
//
// Directed, table-driven bench for target_box_tracker. Each table row is a
// frame: a rectangular pixel block, two optional corner pixels, and the en
// level. The row also holds the box expected after that frame's publish.
// Hand-written sequences cover reset values, the discarded first frame, the
// vsync/match collision, a mid-frame reset, and publish latency.
// Inputs change on the falling edge. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_target_box_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [48:0] i_pack;
  logic [10:0] start_x, end_x;
  logic [9:0]  start_y, end_y;
  logic [23:0] color;
  logic        box_valid;
  logic [19:0] pix_count;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;
  int tick_cnt = 0;

  always #5 clk = ~clk;

  target_box_tracker dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .i_pack     (i_pack),
    .start_x    (start_x),
    .start_y    (start_y),
    .end_x      (end_x),
    .end_y      (end_y),
    .color      (color),
    .box_valid  (box_valid),
    .pix_count  (pix_count),
    .frame_tick (frame_tick)
  );

  // Count publish pulses independently of the checking code.
  always @(posedge clk) if (frame_tick) tick_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          x0, y0, w, h;
    logic [23:0] rgb;
    logic        corners;
    logic        en;
    int          sx, sy, ex, ey;
    logic        valid;
    int          pc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [48:0] mk(input logic vs, input logic hs, input logic de,
                                     input logic [23:0] rgb, input logic [10:0] x,
                                     input logic [9:0] y);
    return {1'b0, vs, hs, de, rgb, x, y};
  endfunction

  task automatic drive(input logic [48:0] p);
    i_pack = p;
    @(negedge clk);
  endtask

  task automatic block(input int x0, input int y0, input int w, input int h,
                       input logic [23:0] rgb);
    for (int y = y0; y < y0 + h; y++) begin
      for (int x = x0; x < x0 + w; x++)
        drive(mk(1'b0, 1'b0, 1'b1, rgb, 11'(x), 10'(y)));
      drive(mk(1'b0, 1'b1, 1'b0, 24'h0, 11'd0, 10'd0));
    end
  endtask

  // Frame boundary. The first vsync cycle can carry a matching pixel, which
  // exercises the edge-wins rule. Enough idle cycles follow to let the publish
  // settle.
  task automatic vsync(input logic collide);
    drive(mk(1'b1, 1'b0, collide, 24'hFF0000, 11'd1000, 10'd600));
    drive(mk(1'b1, 1'b0, 1'b0, 24'h0, 11'd0, 10'd0));
    repeat (6) drive('0);
  endtask

  task automatic check_box(input string tag, input int sx, input int sy, input int ex,
                           input int ey, input logic valid, input int pc);
    check({tag, " start_x"},   32'(start_x),   32'(sx));
    check({tag, " start_y"},   32'(start_y),   32'(sy));
    check({tag, " end_x"},     32'(end_x),     32'(ex));
    check({tag, " end_y"},     32'(end_y),     32'(ey));
    check({tag, " box_valid"}, 32'(box_valid), 32'(valid));
    check({tag, " color"},     32'(color),     valid ? 32'h00FF00 : 32'h0);
    check({tag, " pix_count"}, 32'(pix_count), 32'(pc));
  endtask

  initial begin
    int t0;
    //           x0   y0   w   h  rgb          crn   en    sx   sy   ex    ey   v     pc
    vecs[0] = '{100,  50, 20, 10, 24'hFF0000, 1'b0, 1'b1, 100,  50, 119,   59, 1'b1, 200};
    vecs[1] = '{ 10,  10,  5,  5, 24'hFF0000, 1'b0, 1'b1, 100,  50, 119,   59, 1'b1,  25};
    vecs[2] = '{ 10,  10,  5,  5, 24'hFF0000, 1'b0, 1'b1, 100,  50, 119,   59, 1'b1,  25};
    vecs[3] = '{ 10,  10,  5,  5, 24'hFF0000, 1'b0, 1'b1,   0,   0,   0,    0, 1'b0,  25};
    vecs[4] = '{200, 100,  8,  8, 24'hA05050, 1'b0, 1'b1, 200, 100, 207,  107, 1'b1,  64};
    vecs[5] = '{300, 300, 10, 10, 24'h9F0000, 1'b0, 1'b1, 200, 100, 207,  107, 1'b1,   0};
    vecs[6] = '{ 40,  40,  9,  7, 24'hFF0000, 1'b0, 1'b1, 200, 100, 207,  107, 1'b1,  63};
    vecs[7] = '{500, 300, 31,  2, 24'hFF0000, 1'b1, 1'b1,   0,   0, 1279, 719, 1'b1,  64};
    vecs[8] = '{100,  50, 20, 10, 24'hFF0000, 1'b0, 1'b0,   0,   0,   0,    0, 1'b0, 200};
    vecs[9] = '{100,  50, 20, 10, 24'hFF0000, 1'b0, 1'b1, 100,  50, 119,   59, 1'b1, 200};

    rst = 1'b1;
    en = 1'b1;
    i_pack = '0;
    repeat (3) @(negedge clk);
    check_box("reset", 0, 0, 0, 0, 1'b0, 0);
    check("reset frame_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;

    // The first frame after reset is discarded and produces no tick.
    block(100, 50, 20, 10, 24'hFF0000);
    vsync(1'b0);
    check("first frame no tick", 32'(tick_cnt), 32'd0);
    check("first frame pix_count", 32'(pix_count), 32'd0);

    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      t0 = tick_cnt;
      en = vecs[i].en;
      if (vecs[i].corners) begin
        drive(mk(1'b0, 1'b0, 1'b1, 24'hFF0000, 11'd0, 10'd0));
        drive(mk(1'b0, 1'b0, 1'b1, 24'hFF0000, 11'd1279, 10'd719));
      end
      block(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].rgb);
      vsync(1'b0);
      check({tag, " one tick"}, 32'(tick_cnt), 32'(t0 + 1));
      check_box(tag, vecs[i].sx, vecs[i].sy, vecs[i].ex, vecs[i].ey,
                vecs[i].valid, vecs[i].pc);
    end
    en = 1'b1;

    // A match on the vsync edge cycle is not counted in either frame.
    block(200, 100, 8, 8, 24'hFF0000);
    vsync(1'b1);
    check_box("collide", 200, 100, 207, 107, 1'b1, 64);
    vsync(1'b0);
    check_box("after collide", 200, 100, 207, 107, 1'b1, 0);

    // Mid-frame reset: all outputs return to zero on the next cycle.
    block(10, 10, 8, 8, 24'hFF0000);
    rst = 1'b1;
    drive(mk(1'b0, 1'b0, 1'b1, 24'hFF0000, 11'd20, 10'd20));
    rst = 1'b0;
    check_box("mid reset", 0, 0, 0, 0, 1'b0, 0);
    check("mid reset frame_tick", 32'(frame_tick), 32'd0);
    block(100, 50, 20, 10, 24'hFF0000);
    t0 = tick_cnt;
    vsync(1'b0);
    check("post reset 1st edge no tick", 32'(tick_cnt), 32'(t0));

    // Second edge after reset: frame_tick is high on the 4th cycle after
    // vsync first appears on i_pack, and only on that cycle.
    block(100, 50, 20, 10, 24'hFF0000);
    drive(mk(1'b1, 1'b0, 1'b0, 24'h0, 11'd0, 10'd0));
    check("latency c1", 32'(frame_tick), 32'd0);
    drive(mk(1'b1, 1'b0, 1'b0, 24'h0, 11'd0, 10'd0));
    check("latency c2", 32'(frame_tick), 32'd0);
    drive('0);
    check("latency c3", 32'(frame_tick), 32'd0);
    drive('0);
    check("latency c4", 32'(frame_tick), 32'd1);
    drive('0);
    check("latency c5", 32'(frame_tick), 32'd0);
    check_box("post reset", 100, 50, 119, 59, 1'b1, 200);
    check("post reset one tick", 32'(tick_cnt), 32'(t0 + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
